// File: rtl/hazard_scoreboard.sv
// Pipeline hazard scoreboard: load-use, RAW/WAW on multicycle results, unit busy.
// Optional stall counter enabled by defining HAZARD_PERF_CNT_EN.
module hazard_scoreboard #(
  parameter int NUM_UNITS = 2,
  parameter int REG_W     = 5
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 pc_sel_mem,
  input  logic                 id_valid,
  input  logic [REG_W-1:0]     rs1_id,
  input  logic [REG_W-1:0]     rs2_id,
  input  logic [REG_W-1:0]     rs3_id,
  input  logic [2:0]           use_rs_id,
  input  logic [2:0]           rs_fp_id,
  input  logic [REG_W-1:0]     rd_id,
  input  logic                 rd_we_id,
  input  logic                 rd_fp_id,
  input  logic [NUM_UNITS-1:0] unit_req_id,
  input  logic                 mem_read_exe,
  input  logic [REG_W-1:0]     rd_exe,
  input  logic                 rd_fp_exe,
  input  logic [NUM_UNITS-1:0] unit_done,
  output logic                 load_hazard,
  output logic                 branch_hazard,
  output logic                 multicycle_hazard,
  output logic                 raw_hazard,
  output logic                 waw_hazard,
  output logic                 stall_id,
`ifdef HAZARD_PERF_CNT_EN
  output logic [31:0]          stall_cnt,
`endif
  output logic [NUM_UNITS-1:0] unit_busy
);

  localparam int NREG = 1 << REG_W;

  logic [NUM_UNITS-1:0]            busy_q, busy_d;
  logic [NUM_UNITS-1:0]            fp_q, fp_d;
  logic [NUM_UNITS-1:0]            wr_q, wr_d;
  logic [NUM_UNITS-1:0][REG_W-1:0] tag_q, tag_d;
  logic [NREG-1:0]                 pi_q, pi_d;
  logic [NREG-1:0]                 pf_q, pf_d;

  logic [REG_W-1:0] rs_idx [3];
  logic             issue;
  logic             dst_ok;

  assign rs_idx[0] = rs1_id;
  assign rs_idx[1] = rs2_id;
  assign rs_idx[2] = rs3_id;

  always_comb begin
    raw_hazard  = 1'b0;
    load_hazard = 1'b0;
    for (int i = 0; i < 3; i++) begin
      if (use_rs_id[i]) begin
        if (rs_fp_id[i])
          raw_hazard = raw_hazard | pf_q[rs_idx[i]];
        else if (rs_idx[i] != '0)
          raw_hazard = raw_hazard | pi_q[rs_idx[i]];
        if (mem_read_exe && rs_fp_id[i] == rd_fp_exe &&
            rs_idx[i] == rd_exe && (rd_fp_exe || rd_exe != '0))
          load_hazard = 1'b1;
      end
    end
    raw_hazard  = raw_hazard & id_valid;
    load_hazard = load_hazard & id_valid;
  end

  assign waw_hazard = id_valid & rd_we_id &
                      (rd_fp_id ? pf_q[rd_id] : pi_q[rd_id]);

  assign multicycle_hazard = id_valid &
                             (|(unit_req_id & busy_q & ~unit_done));

  assign branch_hazard = pc_sel_mem;
  assign stall_id = load_hazard | multicycle_hazard |
                    raw_hazard | waw_hazard;
  assign unit_busy = busy_q;

  assign issue  = id_valid & (|unit_req_id) & ~stall_id & ~pc_sel_mem;
  assign dst_ok = rd_we_id & (rd_fp_id | (rd_id != '0));

  // Completions are applied first so a same-cycle issue wins.
  always_comb begin
    busy_d = busy_q;
    fp_d   = fp_q;
    wr_d   = wr_q;
    tag_d  = tag_q;
    pi_d   = pi_q;
    pf_d   = pf_q;
    for (int u = 0; u < NUM_UNITS; u++) begin
      if (unit_done[u] && busy_q[u]) begin
        busy_d[u] = 1'b0;
        if (wr_q[u]) begin
          if (fp_q[u]) pf_d[tag_q[u]] = 1'b0;
          else         pi_d[tag_q[u]] = 1'b0;
        end
      end
    end
    for (int u = 0; u < NUM_UNITS; u++) begin
      if (issue && unit_req_id[u]) begin
        busy_d[u] = 1'b1;
        tag_d[u]  = rd_id;
        fp_d[u]   = rd_fp_id;
        wr_d[u]   = dst_ok;
      end
    end
    if (issue && dst_ok) begin
      if (rd_fp_id) pf_d[rd_id] = 1'b1;
      else          pi_d[rd_id] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      busy_q <= '0;
      fp_q   <= '0;
      wr_q   <= '0;
      tag_q  <= '0;
      pi_q   <= '0;
      pf_q   <= '0;
    end else begin
      busy_q <= busy_d;
      fp_q   <= fp_d;
      wr_q   <= wr_d;
      tag_q  <= tag_d;
      pi_q   <= pi_d;
      pf_q   <= pf_d;
    end
  end

`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] stall_cnt_q;

  always_ff @(posedge clk) begin
    if (reset)         stall_cnt_q <= '0;
    else if (stall_id) stall_cnt_q <= stall_cnt_q + 32'd1;
  end

  assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed bench for hazard_scoreboard with an expected-value queue.
// Output vector: {load,branch,multi,raw,waw,stall,busy[1:0]}.
module tb_hazard_scoreboard;

  logic       clk = 1'b0;
  logic       reset;
  logic       pc_sel_mem;
  logic       id_valid;
  logic [4:0] rs1_id, rs2_id, rs3_id;
  logic [2:0] use_rs_id, rs_fp_id;
  logic [4:0] rd_id;
  logic       rd_we_id, rd_fp_id;
  logic [1:0] unit_req_id;
  logic       mem_read_exe;
  logic [4:0] rd_exe;
  logic       rd_fp_exe;
  logic [1:0] unit_done;
  logic       load_hazard, branch_hazard, multicycle_hazard;
  logic       raw_hazard, waw_hazard, stall_id;
  logic [1:0] unit_busy;
`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] stall_cnt;
`endif

  int checks = 0;
  int errors = 0;

  typedef struct {
    string      tag;
    logic [7:0] val;
  } exp_t;

  exp_t sb[$];

  always #5 clk = ~clk;

  hazard_scoreboard dut (
    .clk               (clk),
    .reset             (reset),
    .pc_sel_mem        (pc_sel_mem),
    .id_valid          (id_valid),
    .rs1_id            (rs1_id),
    .rs2_id            (rs2_id),
    .rs3_id            (rs3_id),
    .use_rs_id         (use_rs_id),
    .rs_fp_id          (rs_fp_id),
    .rd_id             (rd_id),
    .rd_we_id          (rd_we_id),
    .rd_fp_id          (rd_fp_id),
    .unit_req_id       (unit_req_id),
    .mem_read_exe      (mem_read_exe),
    .rd_exe            (rd_exe),
    .rd_fp_exe         (rd_fp_exe),
    .unit_done         (unit_done),
    .load_hazard       (load_hazard),
    .branch_hazard     (branch_hazard),
    .multicycle_hazard (multicycle_hazard),
    .raw_hazard        (raw_hazard),
    .waw_hazard        (waw_hazard),
    .stall_id          (stall_id),
`ifdef HAZARD_PERF_CNT_EN
    .stall_cnt         (stall_cnt),
`endif
    .unit_busy         (unit_busy)
  );

  task automatic clr();
    pc_sel_mem   = 1'b0;
    id_valid     = 1'b0;
    rs1_id       = '0;
    rs2_id       = '0;
    rs3_id       = '0;
    use_rs_id    = '0;
    rs_fp_id     = '0;
    rd_id        = '0;
    rd_we_id     = 1'b0;
    rd_fp_id     = 1'b0;
    unit_req_id  = '0;
    mem_read_exe = 1'b0;
    rd_exe       = '0;
    rd_fp_exe    = 1'b0;
    unit_done    = '0;
  endtask

  // Push the expectation, sample mid-cycle, pop and compare, move on.
  task automatic step(input string tag, input logic [7:0] val);
    exp_t e;
    logic [7:0] obs;
    sb.push_back('{tag, val});
    #2;
    obs = {load_hazard, branch_hazard, multicycle_hazard,
           raw_hazard, waw_hazard, stall_id, unit_busy};
    e = sb.pop_front();
    checks++;
    assert (obs === e.val) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", e.tag, obs, e.val);
    end
    @(negedge clk);
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  initial begin
    clr();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;

    step("rst_idle", 8'b00000000);

    clr(); id_valid = 1; unit_req_id = 2'b10; rd_id = 5; rd_we_id = 1;
    step("div_issue", 8'b00000000);

    clr(); id_valid = 1; use_rs_id = 3'b001; rs1_id = 5;
    step("raw_x5", 8'b00010110);
    unit_done = 2'b10;
    step("raw_x5_done", 8'b00010110);
    unit_done = 2'b00;
    step("raw_x5_clear", 8'b00000000);

    clr(); id_valid = 1; unit_req_id = 2'b10; rd_id = 6; rd_we_id = 1;
    step("div_issue2", 8'b00000000);

    clr(); id_valid = 1; unit_req_id = 2'b10;
    step("mc_busy", 8'b00100110);
    unit_done = 2'b10;
    step("mc_b2b", 8'b00000010);

    clr(); id_valid = 1; use_rs_id = 3'b001; rs1_id = 6;
    step("busy_stays", 8'b00000010);

    clr(); unit_done = 2'b11;
    step("done_idle_unit", 8'b00000010);
    clr();
    step("units_idle", 8'b00000000);

    clr(); id_valid = 1; unit_req_id = 2'b01;
    rd_id = 3; rd_we_id = 1; rd_fp_id = 1;
    step("fsq_issue", 8'b00000000);

    clr(); id_valid = 1; rd_id = 3; rd_we_id = 1; rd_fp_id = 1;
    use_rs_id = 3'b010; rs2_id = 3; rs_fp_id = 3'b010;
    step("waw_raw_f3", 8'b00011101);

    rd_fp_id = 0; rs_fp_id = 3'b000;
    step("int_x3", 8'b00000001);

    clr(); reset = 1; id_valid = 1; unit_req_id = 2'b10;
    rd_id = 8; rd_we_id = 1; unit_done = 2'b01;
    tick();
    reset = 0;

    clr(); id_valid = 1; use_rs_id = 3'b010; rs2_id = 3; rs_fp_id = 3'b010;
    step("rst_f3", 8'b00000000);

    clr(); id_valid = 1; mem_read_exe = 1; rd_exe = 0;
    use_rs_id = 3'b001; rs1_id = 0;
    step("ld_x0", 8'b00000000);

    rd_exe = 7; rs1_id = 7; rs_fp_id = 3'b001;
    step("ld_fp_mix", 8'b00000000);

    rs_fp_id = 3'b000;
    step("ld_x7", 8'b10000100);

    clr(); pc_sel_mem = 1; id_valid = 1; unit_req_id = 2'b10;
    rd_id = 9; rd_we_id = 1;
    step("flush_issue", 8'b01000000);

    clr(); id_valid = 1; use_rs_id = 3'b001; rs1_id = 9;
    step("flush_none", 8'b00000000);

    clr(); id_valid = 1; unit_req_id = 2'b01;
    rd_id = 0; rd_we_id = 1; rd_fp_id = 1;
    step("f0_issue", 8'b00000000);

    clr(); id_valid = 1; use_rs_id = 3'b001; rs1_id = 0; rs_fp_id = 3'b001;
    step("f0_raw", 8'b00010101);

    rs_fp_id = 3'b000;
    step("x0_int", 8'b00000001);

    clr(); unit_done = 2'b01;
    step("f0_done", 8'b00000001);

    clr(); id_valid = 1; use_rs_id = 3'b001; rs1_id = 0; rs_fp_id = 3'b001;
    step("f0_clear", 8'b00000000);

`ifdef HAZARD_PERF_CNT_EN
    clr(); reset = 1;
    tick();
    reset = 0;
    id_valid = 1; mem_read_exe = 1; rd_exe = 7;
    use_rs_id = 3'b001; rs1_id = 7;
    repeat (5) tick();
    clr();
    #2;
    checks++;
    assert (stall_cnt === 32'd5) else begin
      errors++;
      $error("FAIL cnt5 observed=%0d expected=5", stall_cnt);
    end
    tick();
    dut.stall_cnt_q = 32'hFFFF_FFFF;
    id_valid = 1; mem_read_exe = 1; rd_exe = 7;
    use_rs_id = 3'b001; rs1_id = 7;
    tick();
    clr();
    #2;
    checks++;
    assert (stall_cnt === 32'd0) else begin
      errors++;
      $error("FAIL cnt_wrap observed=%0h expected=0", stall_cnt);
    end
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/hazard_scoreboard.md
HAZARD_SCOREBOARD -- requirements
Module: hazard_scoreboard

Interface
REQ-001 SHALL have parameter NUM_UNITS, default 2, number of multicycle units (legal 1..8; bit 1 = divider, bit 0 = fsqrt at default).
REQ-002 SHALL have parameter REG_W, default 5, architectural register index width.
REQ-003 SHALL have ports: clk input 1 clock; reset input 1 synchronous active-high reset.
REQ-004 SHALL have port pc_sel_mem input 1 taken branch/jump resolved in MEM.
REQ-005 SHALL have port id_valid input 1 ID holds a valid instruction.
REQ-006 SHALL have ports rs1_id, rs2_id, rs3_id input REG_W each, ID source indices.
REQ-007 SHALL have ports use_rs_id input 3, source-used flags; rs_fp_id input 3, source is FP file (bit i = rsi+1).
REQ-008 SHALL have ports rd_id input REG_W; rd_we_id input 1; rd_fp_id input 1, ID destination.
REQ-009 SHALL have port unit_req_id input NUM_UNITS, one-hot multicycle unit requested by ID (zero = none).
REQ-010 SHALL have ports mem_read_exe input 1; rd_exe input REG_W; rd_fp_exe input 1, load in EXE.
REQ-011 SHALL have port unit_done input NUM_UNITS, one-cycle completion pulse per unit.
REQ-012 SHALL have outputs load_hazard, branch_hazard, multicycle_hazard, raw_hazard, waw_hazard, stall_id (1 each) and unit_busy (NUM_UNITS).

Function
REQ-013 SHALL keep per-unit state: busy bit, REG_W-bit tag, FP bit; plus 2x2^REG_W pending bits (integer, FP).
REQ-014 SHALL define issue = id_valid & |unit_req_id & !stall_id & !pc_sel_mem.
REQ-015 SHALL on issue set busy[u], capture tag/FP of unit u, set pending for rd if rd_we_id and not integer x0; visible next cycle.
REQ-016 SHALL on unit_done[u] with busy[u] clear busy[u] and its pending bit next cycle; unit_done on idle unit ignored.
REQ-017 SHALL give set priority over clear when issue and done hit the same unit or register in one cycle.
REQ-018 SHALL assert multicycle_hazard when id_valid and unit_req_id[u] and busy[u] and !unit_done[u] (done same cycle permits back-to-back).
REQ-019 SHALL assert raw_hazard when any used source ({fp,idx}) has its registered pending bit set; integer x0 never hazards; f0 does.
REQ-020 SHALL assert waw_hazard when id_valid, rd_we_id and destination pending bit set.
REQ-021 SHALL assert load_hazard when id_valid, mem_read_exe, rd_exe matches a used source of same file, excluding integer x0.
REQ-022 SHALL drive branch_hazard = pc_sel_mem combinationally.
REQ-023 SHALL drive stall_id = OR of load, multicycle, raw, waw hazards; branch_hazard excluded.
REQ-024 SHALL let in-flight units finish on flush; pending released on their unit_done.
REQ-025 SHALL drive unit_busy from registered busy bits.

Reset
REQ-026 SHALL on reset clear all busy, tag, FP and pending bits; all outputs 0 next cycle given idle inputs.
REQ-027 SHALL give reset priority over simultaneous issue and unit_done.

Configuration
REQ-028 SHALL with HAZARD_PERF_CNT_EN add output stall_cnt 32 bits, incrementing each cycle stall_id=1, wrapping 0xFFFFFFFF->0, reset 0.
REQ-029 SHALL without HAZARD_PERF_CNT_EN omit stall_cnt port and counter logic.

Verification
REQ-030 SHALL check: issue div rd=x5, next cycle ID uses rs1=x5 -> raw_hazard=1 until cycle after unit_done[1].
REQ-031 SHALL check: div busy, ID requests div -> multicycle_hazard=1; same with unit_done[1] in that cycle -> 0, issue accepted, busy stays 1.
REQ-032 SHALL check: load rd_exe=x0, rs1_id=x0 used -> load_hazard=0; rd_exe=x7 int vs FP rs=f7 -> 0; int x7 -> 1.
REQ-033 SHALL check: issue with pc_sel_mem=1 -> no busy set, no pending set.
REQ-034 SHALL check: reset asserted while fsqrt busy with f3 pending -> unit_busy=0, raw_hazard on f3 = 0 next cycle.
REQ-035 SHALL check (HAZARD_PERF_CNT_EN): 5 stall cycles from reset -> stall_cnt=5; preload 0xFFFFFFFF plus one stall -> 0.
